// File: rtl/issue_unit_pkg.sv
// Shared types for the issue scheduler: functional-unit ids and CDB slots.
package issue_unit_pkg;

  typedef enum logic [1:0] {
    FU_INT  = 2'd0,
    FU_MULT = 2'd1,
    FU_DIV  = 2'd2,
    FU_LDST = 2'd3
  } fu_id_e;

  // One entry of the CDB reservation table.
  typedef struct packed {
    logic   valid;
    fu_id_e fu;
  } cdb_slot_t;

endpackage

// File: rtl/issue_unit_if.sv
// Issue-queue / CDB signal bundle between the queues and the scheduler.
// Handshake: each *_ready is a level meaning "queue head may issue this
// cycle"; the matching *_issue is a same-cycle grant that pops the head.
// A ready may drop without a grant; nothing is remembered per request.
interface issue_unit_if;
  import issue_unit_pkg::*;

  logic   int_ready;
  logic   mult_ready;
  logic   div_ready;
  logic   ld_st_ready;
  logic   int_issue;
  logic   mult_issue;
  logic   div_issue;
  logic   ld_st_issue;
  logic   div_busy;
  logic   cdb_valid;
  fu_id_e cdb_fu;

  // Queue side.
  modport master (
    output int_ready, mult_ready, div_ready, ld_st_ready,
    input  int_issue, mult_issue, div_issue, ld_st_issue,
    input  div_busy, cdb_valid, cdb_fu
  );

  // Scheduler side.
  modport slave (
    input  int_ready, mult_ready, div_ready, ld_st_ready,
    output int_issue, mult_issue, div_issue, ld_st_issue,
    output div_busy, cdb_valid, cdb_fu
  );
endinterface

// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter: search starts at the index after last_i.
module rr_arbiter4
  import issue_unit_pkg::*;
(
  input  logic [3:0] elig_i,
  input  fu_id_e     last_i,
  output logic [3:0] gnt_oh_o,
  output fu_id_e     gnt_idx_o,
  output logic       any_o
);

  logic [1:0] idx;

  // Pick the first eligible requester in rotating order after last_i.
  always_comb begin
    gnt_oh_o  = 4'b0000;
    gnt_idx_o = FU_INT;
    any_o     = 1'b0;
    idx       = 2'd0;
    for (int off = 1; off <= 4; off++) begin
      idx = last_i + 2'(off);
      if (!any_o && elig_i[idx]) begin
        any_o         = 1'b1;
        gnt_oh_o[idx] = 1'b1;
        gnt_idx_o     = fu_id_e'(idx);
      end
    end
  end

endmodule

// File: rtl/issue_unit.sv
// Single-issue scheduler: grants one issue queue per cycle, reserving the
// CDB slot its result will occupy and tracking the non-pipelined divider.
module issue_unit
  import issue_unit_pkg::*;
#(
  parameter int INT_LAT  = 1,
  parameter int LDST_LAT = 2,
  parameter int MULT_LAT = 4,
  parameter int DIV_LAT  = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  issue_unit_if.slave bus
);

  localparam int IW = $clog2(DIV_LAT + 1);

  if (INT_LAT < 1 || LDST_LAT < 1 || MULT_LAT < 1 || DIV_LAT > 15 ||
      INT_LAT > DIV_LAT || LDST_LAT > DIV_LAT || MULT_LAT > DIV_LAT) begin : g_bad_lat
    $error("issue_unit: latencies must be 1..15 with DIV_LAT the largest");
  end

  // res_q[k] is the CDB owner k cycles from now.
  cdb_slot_t res_q [0:DIV_LAT];
  cdb_slot_t res_d [0:DIV_LAT];
  logic [3:0] div_cnt_q, div_cnt_d;
  fu_id_e     last_q, last_d;

  logic [3:0] elig;
  logic [3:0] gnt_oh;
  fu_id_e     gnt_idx;
  logic       any_gnt;
  logic [IW-1:0] wr_idx;

  // A unit is eligible when its broadcast slot is free; div also needs the divider idle.
  always_comb begin
    elig[0] = bus.int_ready   && !res_q[INT_LAT].valid;
    elig[1] = bus.mult_ready  && !res_q[MULT_LAT].valid;
    elig[2] = bus.div_ready   && !res_q[DIV_LAT].valid && (div_cnt_q == 4'd0);
    elig[3] = bus.ld_st_ready && !res_q[LDST_LAT].valid;
    if (rst || flush) elig = 4'b0000;
  end

  rr_arbiter4 u_arb (
    .elig_i    (elig),
    .last_i    (last_q),
    .gnt_oh_o  (gnt_oh),
    .gnt_idx_o (gnt_idx),
    .any_o     (any_gnt)
  );

  assign bus.int_issue   = gnt_oh[0];
  assign bus.mult_issue  = gnt_oh[1];
  assign bus.div_issue   = gnt_oh[2];
  assign bus.ld_st_issue = gnt_oh[3];
  assign bus.div_busy    = (div_cnt_q != 4'd0);
  assign bus.cdb_valid   = res_q[0].valid;
  assign bus.cdb_fu      = res_q[0].fu;

  // Shift the table, book the granted unit's slot, run the divider countdown.
  always_comb begin
    for (int i = 0; i < DIV_LAT; i++) res_d[i] = res_q[i+1];
    res_d[DIV_LAT] = '0;
    case (gnt_idx)
      FU_INT:  wr_idx = IW'(INT_LAT - 1);
      FU_MULT: wr_idx = IW'(MULT_LAT - 1);
      FU_DIV:  wr_idx = IW'(DIV_LAT - 1);
      default: wr_idx = IW'(LDST_LAT - 1);
    endcase
    if (any_gnt) res_d[wr_idx] = '{valid: 1'b1, fu: gnt_idx};
    div_cnt_d = (div_cnt_q != 4'd0) ? div_cnt_q - 4'd1 : 4'd0;
    if (any_gnt && gnt_idx == FU_DIV) div_cnt_d = 4'(DIV_LAT - 1);
    last_d = any_gnt ? gnt_idx : last_q;
    if (flush) begin
      for (int i = 0; i <= DIV_LAT; i++) res_d[i] = '0;
      div_cnt_d = 4'd0;
    end
  end

  // State registers; reset leaves int with first priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= DIV_LAT; i++) res_q[i] <= '0;
      div_cnt_q <= 4'd0;
      last_q    <= FU_LDST;
    end else begin
      for (int i = 0; i <= DIV_LAT; i++) res_q[i] <= res_d[i];
      div_cnt_q <= div_cnt_d;
      last_q    <= last_d;
    end
  end

endmodule
